// File: rtl/mem_store_pkg.sv
// Shared MIPS definitions for the MEM-stage store path: store-op encodings,
// default data-memory size and the byte-lane merge helper.
package mips_defs;

    // Store-op encodings carried on Store_mem
    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_W    = 2'b01;
    localparam logic [1:0] ST_H    = 2'b10;
    localparam logic [1:0] ST_B    = 2'b11;

    // Default word-address width: 2^10 words = 4 KiB
    localparam int ADDR_WIDTH_DEF = 10;

    // Replace the byte lanes of old_w selected by be with the lanes of new_w
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ext_store.sv
// Store aligner: turns a store op and the low address bits into byte-lane
// enables and lane-replicated write data. Mirror image of the WB load extender.
module ext_store
    import mips_defs::*;
(
    input  logic [1:0]  A,
    input  logic [31:0] Din,
    input  logic [1:0]  Op,
    output logic [3:0]  BE,
    output logic [31:0] DOut,
    output logic        Err
);

    // Lane enables, replicated data and alignment error for the current op
    always_comb begin
        BE   = 4'b0000;
        DOut = Din;
        Err  = 1'b0;
        case (Op)
            ST_W: begin
                DOut = Din;
                if (A != 2'b00) begin
                    Err = 1'b1;
                    BE  = 4'b0000;
                end else begin
                    BE  = 4'b1111;
                end
            end
            ST_H: begin
                DOut = {2{Din[15:0]}};
                if (A[0]) begin
                    Err = 1'b1;
                    BE  = 4'b0000;
                end else if (A[1]) begin
                    BE  = 4'b1100;
                end else begin
                    BE  = 4'b0011;
                end
            end
            ST_B: begin
                DOut = {4{Din[7:0]}};
                BE   = 4'b0001 << A;
            end
            ST_NONE: begin
                BE   = 4'b0000;
                DOut = Din;
            end
            default: begin
                BE   = 4'b0000;
                DOut = Din;
                Err  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_store.sv
// MEM-stage data memory: aligns and writes stores into a word-organised RAM
// and registers the raw (write-first) addressed word into the MEM/WB boundary.
// Load extension is left entirely to the WB stage.
module mem_store
    import mips_defs::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  Store_mem,
    input  logic [31:0] aluout_mem,
    input  logic [31:0] wdata_mem,
    input  logic [31:0] pc_mem,
    output logic [3:0]  byte_en_mem,
    output logic [31:0] dmout_wb,
    output logic        store_err_wb
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           r_mem [0:DEPTH-1];

    logic [3:0]            w_ext_be;
    logic [31:0]           w_ext_data;
    logic                  w_align_err;
    logic                  w_range_err;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [31-ADDR_WIDTH-2:0] w_upper;
    logic [3:0]            w_be;
    logic [31:0]           w_old;
    logic [31:0]           w_merged;
    logic                  w_unused_pc;

    // The PC only feeds the simulation write log outside this block
    assign w_unused_pc = ^pc_mem;

    ext_store u_ext_store (
        .A    (aluout_mem[1:0]),
        .Din  (wdata_mem),
        .Op   (Store_mem),
        .BE   (w_ext_be),
        .DOut (w_ext_data),
        .Err  (w_align_err)
    );

    assign w_idx   = aluout_mem[ADDR_WIDTH+1:2];
    assign w_upper = aluout_mem[31:ADDR_WIDTH+2];

    // Range check and final lane enables; an erroring store writes nothing
    always_comb begin
        w_range_err = 1'b0;
        w_be        = w_ext_be;
        if ((Store_mem != ST_NONE) && (w_upper != '0)) begin
            w_range_err = 1'b1;
            w_be        = 4'b0000;
        end else begin
            w_range_err = 1'b0;
            w_be        = w_ext_be;
        end
    end

    assign byte_en_mem = w_be;

    // Write-first view: the word as it will look after this cycle's store
    assign w_old    = r_mem[w_idx];
    assign w_merged = merge_lanes(w_old, w_ext_data, w_be);

    // RAM array: cleared asynchronously by reset, enabled lanes written at the edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0000_0000;
            end
        end else if (w_be != 4'b0000) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    // MEM/WB boundary registers: raw merged word and store-error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dmout_wb     <= 32'h0000_0000;
            store_err_wb <= 1'b0;
        end else begin
            dmout_wb     <= w_merged;
            store_err_wb <= w_align_err | w_range_err;
        end
    end

endmodule

// File: tb/tb_mem_store.sv
// Directed bench for mem_store: reset, sw/sh/sb merging, misaligned and
// out-of-range stores, write-first capture and asynchronous mid-run reset.
module tb_mem_store;

    logic        clk;
    logic        reset_n;
    logic [1:0]  Store_mem;
    logic [31:0] aluout_mem;
    logic [31:0] wdata_mem;
    logic [31:0] pc_mem;
    logic [3:0]  byte_en_mem;
    logic [31:0] dmout_wb;
    logic        store_err_wb;

    int n_checks;
    int n_errors;

    logic [31:0] log_pc;
    logic [31:0] log_addr;

    mem_store #(.ADDR_WIDTH(10)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .Store_mem    (Store_mem),
        .aluout_mem   (aluout_mem),
        .wdata_mem    (wdata_mem),
        .pc_mem       (pc_mem),
        .byte_en_mem  (byte_en_mem),
        .dmout_wb     (dmout_wb),
        .store_err_wb (store_err_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log: one line per committed store
    always @(posedge clk) begin
        if (reset_n && (byte_en_mem != 4'b0000)) begin
            log_pc   = pc_mem;
            log_addr = {aluout_mem[31:2], 2'b00};
            #1;
            $display("@%08h: *%08h <= %08h", log_pc, log_addr, dmout_wb);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
        Store_mem  = op;
        aluout_mem = addr;
        wdata_mem  = data;
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset_n    = 1'b0;
        Store_mem  = 2'b00;
        aluout_mem = 32'h0;
        wdata_mem  = 32'h0;
        pc_mem     = 32'h0000_3000;

        // 1. Reset
        cyc();
        cyc();
        chk("rst_dmout", dmout_wb, 32'h0);
        chk("rst_err", {31'h0, store_err_wb}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(2'b00, 32'h0000_0000, 32'h0);
        cyc();
        chk("rd0_dmout", dmout_wb, 32'h0);
        chk("rd0_err", {31'h0, store_err_wb}, 32'h0);
        drive(2'b00, 32'h0000_0FFC, 32'h0);
        cyc();
        chk("rdFFC_dmout", dmout_wb, 32'h0);

        // 2. Word store
        pc_mem = 32'h0000_3000;
        drive(2'b01, 32'h0000_0010, 32'h1234_5678);
        chk("sw_be", {28'h0, byte_en_mem}, 32'hF);
        cyc();
        chk("sw_dmout", dmout_wb, 32'h1234_5678);
        chk("sw_err", {31'h0, store_err_wb}, 32'h0);
        pc_mem = 32'h0000_3004;
        drive(2'b00, 32'h0000_0010, 32'h0);
        chk("none_be", {28'h0, byte_en_mem}, 32'h0);
        cyc();
        chk("sw_readback", dmout_wb, 32'h1234_5678);

        // 3. Byte and half merge (back-to-back into the same word)
        pc_mem = 32'h0000_3008;
        drive(2'b11, 32'h0000_0013, 32'h0000_00AB);
        chk("sb_be", {28'h0, byte_en_mem}, 32'h8);
        cyc();
        chk("sb_dmout", dmout_wb, 32'hAB34_5678);
        pc_mem = 32'h0000_300C;
        drive(2'b10, 32'h0000_0010, 32'h0000_CDEF);
        chk("sh_be", {28'h0, byte_en_mem}, 32'h3);
        cyc();
        chk("sh_dmout", dmout_wb, 32'hAB34_CDEF);
        pc_mem = 32'h0000_3010;
        drive(2'b10, 32'h0000_0012, 32'hFFFF_1111);
        chk("sh_hi_be", {28'h0, byte_en_mem}, 32'hC);
        cyc();
        chk("sh_hi_dmout", dmout_wb, 32'h1111_CDEF);

        // 4. Misaligned stores
        drive(2'b10, 32'h0000_0021, 32'h0000_BEEF);
        chk("mis_sh_be", {28'h0, byte_en_mem}, 32'h0);
        cyc();
        chk("mis_sh_err", {31'h0, store_err_wb}, 32'h1);
        chk("mis_sh_dmout", dmout_wb, 32'h0);
        drive(2'b01, 32'h0000_0022, 32'hCAFE_F00D);
        chk("mis_sw_be", {28'h0, byte_en_mem}, 32'h0);
        cyc();
        chk("mis_sw_err", {31'h0, store_err_wb}, 32'h1);
        chk("mis_sw_dmout", dmout_wb, 32'h0);
        drive(2'b00, 32'h0000_0020, 32'h0);
        cyc();
        chk("mis_after_err", {31'h0, store_err_wb}, 32'h0);
        chk("mis_after_word", dmout_wb, 32'h0);

        // 5. Out of range
        drive(2'b01, 32'h0000_1000, 32'hDEAD_BEEF);
        chk("oor_be", {28'h0, byte_en_mem}, 32'h0);
        cyc();
        chk("oor_err", {31'h0, store_err_wb}, 32'h1);
        chk("oor_dmout", dmout_wb, 32'h0);
        drive(2'b11, 32'h8000_0010, 32'h0000_0099);
        chk("oor_sb_be", {28'h0, byte_en_mem}, 32'h0);
        cyc();
        chk("oor_sb_err", {31'h0, store_err_wb}, 32'h1);
        chk("oor_sb_alias", dmout_wb, 32'h1111_CDEF);
        drive(2'b00, 32'h0000_0000, 32'h0);
        cyc();
        chk("oor_word0", dmout_wb, 32'h0);
        chk("oor_err_clr", {31'h0, store_err_wb}, 32'h0);

        // 6. Write-first and reset mid-run
        pc_mem = 32'h0000_3020;
        drive(2'b11, 32'h0000_0031, 32'h0000_005A);
        chk("wf_be", {28'h0, byte_en_mem}, 32'h2);
        cyc();
        chk("wf_dmout", dmout_wb, 32'h0000_5A00);
        pc_mem = 32'h0000_3024;
        drive(2'b11, 32'h0000_0032, 32'h0000_0077);
        chk("sb2_be", {28'h0, byte_en_mem}, 32'h4);
        cyc();
        chk("sb2_dmout", dmout_wb, 32'h0077_5A00);
        drive(2'b01, 32'h0000_0011, 32'h1);
        cyc();
        chk("pre_rst_err", {31'h0, store_err_wb}, 32'h1);
        drive(2'b00, 32'h0000_0010, 32'h0);
        cyc();
        chk("pre_rst_word", dmout_wb, 32'h1111_CDEF);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_dmout", dmout_wb, 32'h0);
        chk("async_rst_err", {31'h0, store_err_wb}, 32'h0);
        drive(2'b01, 32'h0000_0040, 32'h5555_AAAA);
        cyc();
        chk("rst_hold_dmout", dmout_wb, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(2'b00, 32'h0000_0010, 32'h0);
        cyc();
        chk("post_rst_10", dmout_wb, 32'h0);
        drive(2'b00, 32'h0000_0030, 32'h0);
        cyc();
        chk("post_rst_30", dmout_wb, 32'h0);
        drive(2'b00, 32'h0000_0040, 32'h0);
        cyc();
        chk("post_rst_40", dmout_wb, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
